// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: memory-controller read port plus the decoder/datapath handshake.
// The master modport is the fetch unit; the slave modport is the memory/datapath side.
interface instr_fetch_unit_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] imemload;
  logic        ivalid;
  logic        iready;
  logic [2:0]  PCsrc;
  logic        zero;
  logic [31:0] rdat1;
  logic [15:0] imm;
  logic [25:0] addr;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        halted;
  logic [31:0] instr_count;

  modport master (
    output iREN, iaddr, imemload, ivalid, pc, pcplus4, halted, instr_count,
    input  iwait, iload, iready, PCsrc, zero, rdat1, imm, addr, halt
  );

  modport slave (
    input  iREN, iaddr, imemload, ivalid, pc, pcplus4, halted, instr_count,
    output iwait, iload, iready, PCsrc, zero, rdat1, imm, addr, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one read at a time, holds the word
// until the datapath accepts it, then selects the next PC; stops on an accepted HALT.
//
// state  | meaning
// FETCH  | read request outstanding at pc, waiting for iwait=0
// VALID  | imemload holds an unconsumed instruction, waiting for iready
// HALTED | HALT accepted, fetch stopped until reset
module instr_fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic CLK,
  input  logic RST,
  instr_fetch_unit_if.master bus
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] VALID  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] count_q, count_d;
  logic        ivalid_q, ivalid_d;
  logic        halted_q, halted_d;

  logic [31:0] pcplus4;
  logic [31:0] br_target;
  logic [31:0] next_pc;
  logic        accept;

  always_comb begin
    pcplus4   = pc_q + 32'd4;
    br_target = pcplus4 + {{14{bus.imm[15]}}, bus.imm, 2'b00};
    case (bus.PCsrc)
      3'd2:    next_pc = {bus.rdat1[31:2], 2'b00};
      3'd3:    next_pc = {pcplus4[31:28], bus.addr, 2'b00};
      3'd4:    next_pc = bus.zero ? pcplus4 : br_target;
      3'd5:    next_pc = bus.zero ? br_target : pcplus4;
      default: next_pc = pcplus4;
    endcase
  end

  assign accept = (state_q == VALID) && bus.iready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imemload_d = imemload_q;
    count_d    = count_q;
    ivalid_d   = ivalid_q;
    halted_d   = halted_q;
    case (state_q)
      FETCH: begin
        if (!bus.iwait) begin
          imemload_d = bus.iload;
          ivalid_d   = 1'b1;
          state_d    = VALID;
        end
      end
      VALID: begin
        if (accept) begin
          count_d  = count_q + 32'd1;
          ivalid_d = 1'b0;
          // halt wins over any PCsrc selection on the same accept
          if (bus.halt) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= FETCH;
      pc_q       <= PC_INIT;
      imemload_q <= 32'h0;
      count_q    <= 32'h0;
      ivalid_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imemload_q <= imemload_d;
      count_q    <= count_d;
      ivalid_q   <= ivalid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.iREN        = (state_q == FETCH) && !RST;
  assign bus.iaddr       = pc_q;
  assign bus.imemload    = imemload_q;
  assign bus.ivalid      = ivalid_q;
  assign bus.pc          = pc_q;
  assign bus.pcplus4     = pcplus4;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed sequences, a next-PC vector
// table and randomized traffic, all checked against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: what the fetch unit should expose, tracked per transaction.
  logic [31:0] m_pc, m_word, m_cnt;
  logic        m_valid, m_halted;

  typedef struct {
    string       nm;
    logic [31:0] start;
    logic [2:0]  src;
    logic        zero;
    logic [31:0] rdat1;
    logic [15:0] imm;
    logic [25:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[12];

  function automatic logic [31:0] ref_next_pc(input logic [31:0] pc, input logic [2:0] src,
                                              input logic z, input logic [31:0] r1,
                                              input logic [15:0] im, input logic [25:0] ad);
    logic [31:0] p4, off;
    p4  = pc + 32'd4;
    off = {{16{im[15]}}, im} * 32'd4;
    case (src)
      3'd2:    return r1 & 32'hFFFF_FFFC;
      3'd3:    return (p4 & 32'hF000_0000) | ({6'd0, ad} * 32'd4);
      3'd4:    return z ? p4 : p4 + off;
      3'd5:    return z ? p4 + off : p4;
      default: return p4;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("iREN",        {31'd0, bus.iREN},   {31'd0, !m_valid && !m_halted && !RST});
    chk("iaddr",       bus.iaddr,           m_pc);
    chk("pc",          bus.pc,              m_pc);
    chk("pcplus4",     bus.pcplus4,         m_pc + 32'd4);
    chk("ivalid",      {31'd0, bus.ivalid}, {31'd0, m_valid});
    chk("imemload",    bus.imemload,        m_word);
    chk("halted",      {31'd0, bus.halted}, {31'd0, m_halted});
    chk("instr_count", bus.instr_count,     m_cnt);
  endtask

  // One clock: sample inputs at the edge, advance the model, compare, return at negedge.
  task automatic cyc();
    logic s_rst, s_iwait, s_iready, s_zero, s_halt;
    logic [31:0] s_iload, s_rdat1;
    logic [2:0]  s_src;
    logic [15:0] s_imm;
    logic [25:0] s_addr;
    @(posedge CLK);
    s_rst = RST; s_iwait = bus.iwait; s_iload = bus.iload; s_iready = bus.iready;
    s_src = bus.PCsrc; s_zero = bus.zero; s_rdat1 = bus.rdat1; s_imm = bus.imm;
    s_addr = bus.addr; s_halt = bus.halt;
    #1;
    if (s_rst) begin
      m_pc = PC_INIT; m_word = 32'h0; m_cnt = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (!m_valid) begin
      if (!s_iwait) begin
        m_word  = s_iload;
        m_valid = 1'b1;
      end
    end else if (s_iready) begin
      m_cnt   = m_cnt + 32'd1;
      m_valid = 1'b0;
      if (s_halt) m_halted = 1'b1;
      else        m_pc = ref_next_pc(m_pc, s_src, s_zero, s_rdat1, s_imm, s_addr);
    end
    compare_all();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.iwait = 1'b0; bus.iload = 32'h0; bus.iready = 1'b0; bus.PCsrc = 3'd0;
    bus.zero = 1'b0; bus.rdat1 = 32'h0; bus.imm = 16'h0; bus.addr = 26'h0; bus.halt = 1'b0;
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  task automatic do_fetch(input logic [31:0] word);
    bus.iwait = 1'b0; bus.iload = word; bus.iready = 1'b0;
    cyc();
  endtask

  task automatic do_accept(input logic [2:0] src, input logic z, input logic [31:0] r1,
                           input logic [15:0] im, input logic [25:0] ad, input logic h);
    bus.iready = 1'b1; bus.PCsrc = src; bus.zero = z; bus.rdat1 = r1;
    bus.imm = im; bus.addr = ad; bus.halt = h; bus.iwait = 1'b1;
    cyc();
    bus.iready = 1'b0; bus.halt = 1'b0; bus.PCsrc = 3'd0;
  endtask

  initial begin
    logic [31:0] held;
    m_pc = PC_INIT; m_word = 32'h0; m_cnt = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
    idle_inputs();

    vt[0]  = '{"beq_taken",    32'h0000_0010, 3'd5, 1'b1, 32'h0, 16'hFFFC, 26'h0, 32'h0000_0004};
    vt[1]  = '{"beq_not",      32'h0000_0010, 3'd5, 1'b0, 32'h0, 16'hFFFC, 26'h0, 32'h0000_0014};
    vt[2]  = '{"bne_taken",    32'h0000_0010, 3'd4, 1'b0, 32'h0, 16'hFFFC, 26'h0, 32'h0000_0004};
    vt[3]  = '{"bne_not",      32'h0000_0010, 3'd4, 1'b1, 32'h0, 16'hFFFC, 26'h0, 32'h0000_0014};
    vt[4]  = '{"j",            32'h3000_0000, 3'd3, 1'b0, 32'h0, 16'h0, 26'h000_0040, 32'h3000_0100};
    vt[5]  = '{"jr",           32'h0000_0040, 3'd2, 1'b0, 32'h0000_0123, 16'h0, 26'h0, 32'h0000_0120};
    vt[6]  = '{"seq0",         32'h0000_0200, 3'd0, 1'b1, 32'hFFFF_FFFF, 16'h1234, 26'h3FF_FFFF, 32'h0000_0204};
    vt[7]  = '{"seq1",         32'h0000_0200, 3'd1, 1'b1, 32'hFFFF_FFFF, 16'h1234, 26'h3FF_FFFF, 32'h0000_0204};
    vt[8]  = '{"seq6",         32'h0000_0200, 3'd6, 1'b1, 32'hFFFF_FFFF, 16'h1234, 26'h3FF_FFFF, 32'h0000_0204};
    vt[9]  = '{"seq7",         32'h0000_0200, 3'd7, 1'b0, 32'hFFFF_FFFF, 16'h1234, 26'h3FF_FFFF, 32'h0000_0204};
    vt[10] = '{"beq_fwd",      32'h0000_0100, 3'd5, 1'b1, 32'h0, 16'h0010, 26'h0, 32'h0000_0144};
    vt[11] = '{"j_region",     32'h0FFF_FFFC, 3'd3, 1'b0, 32'h0, 16'h0, 26'h3FF_FFFF, 32'h1FFF_FFFC};

    @(negedge CLK);
    reset_dut();

    // First fetch after reset, sequential accept
    #1;
    chk("first_iREN",  {31'd0, bus.iREN}, 32'd1);
    chk("first_iaddr", bus.iaddr, 32'h0);
    do_fetch(32'h2001_0005);
    chk("first_word", bus.imemload, 32'h2001_0005);
    do_accept(3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0);
    chk("second_iaddr", bus.iaddr, 32'h4);
    chk("count_one", bus.instr_count, 32'd1);

    // Memory wait at pc=0x8
    do_fetch(32'hAAAA_0001);
    do_accept(3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0);
    bus.iwait = 1'b1; bus.iload = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("wait_iREN",   {31'd0, bus.iREN}, 32'd1);
      chk("wait_iaddr",  bus.iaddr, 32'h8);
      chk("wait_ivalid", {31'd0, bus.ivalid}, 32'd0);
    end
    do_fetch(32'h1234_5678);
    chk("wait_done_ivalid", {31'd0, bus.ivalid}, 32'd1);

    // Next-PC vector table
    for (int v = 0; v < 12; v++) begin
      reset_dut();
      do_fetch($urandom);
      do_accept(3'd2, 1'b0, vt[v].start, 16'h0, 26'h0, 1'b0);
      chk({vt[v].nm, "_start"}, bus.iaddr, vt[v].start);
      do_fetch($urandom);
      do_accept(vt[v].src, vt[v].zero, vt[v].rdat1, vt[v].imm, vt[v].addr, 1'b0);
      chk(vt[v].nm, bus.iaddr, vt[v].exp);
    end

    // HALT after three instructions, halt beats a taken jump
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      do_fetch($urandom);
      do_accept(3'd0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0);
    end
    do_fetch(32'hFC00_0000);
    do_accept(3'd3, 1'b0, 32'h0, 16'h0, 26'h3FF_FFFF, 1'b1);
    chk("halt_pc", bus.pc, 32'hC);
    for (int i = 0; i < 20; i++) begin
      bus.iwait = 1'($urandom); bus.iload = $urandom; bus.iready = 1'($urandom);
      bus.halt = 1'($urandom); bus.PCsrc = 3'($urandom);
      cyc();
      chk("halt_iREN",   {31'd0, bus.iREN}, 32'd0);
      chk("halt_halted", {31'd0, bus.halted}, 32'd1);
      chk("halt_count",  bus.instr_count, 32'd4);
    end
    reset_dut();
    chk("unhalt_pc",     bus.pc, PC_INIT);
    chk("unhalt_halted", {31'd0, bus.halted}, 32'd0);
    chk("unhalt_count",  bus.instr_count, 32'd0);

    // Backpressure holds imemload, then reset mid-fetch
    do_fetch(32'hCAFE_F00D);
    held = bus.imemload;
    chk("bp_first", held, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      bus.iready = 1'b0; bus.iwait = i[0]; bus.iload = $urandom;
      cyc();
      chk("bp_hold", bus.imemload, 32'hCAFE_F00D);
      chk("bp_ivalid", {31'd0, bus.ivalid}, 32'd1);
    end
    do_accept(3'd2, 1'b0, 32'h0000_0800, 16'h0, 26'h0, 1'b0);
    bus.iwait = 1'b1;
    cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("rst_mid_pc",     bus.pc, PC_INIT);
    chk("rst_mid_ivalid", {31'd0, bus.ivalid}, 32'd0);
    bus.iwait = 1'b0; bus.iload = 32'h5555_AAAA;
    cyc();
    chk("rst_mid_refetch", bus.imemload, 32'h5555_AAAA);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      RST        = ($urandom_range(0, 59) == 0);
      bus.iwait  = ($urandom_range(0, 2) == 0);
      bus.iload  = $urandom;
      bus.iready = ($urandom_range(0, 2) != 0);
      bus.PCsrc  = 3'($urandom);
      bus.zero   = 1'($urandom);
      bus.rdat1  = $urandom;
      bus.imm    = 16'($urandom);
      bus.addr   = 26'($urandom);
      bus.halt   = ($urandom_range(0, 29) == 0);
      cyc();
    end
    RST = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
